// File: rtl/button_cmd_decoder.sv
// Turns debounced button levels into one-shot command tokens behind a valid/ack stage.
// Define BTN_CMD_FIFO_EN to replace the single holding register with a 4-entry FIFO.
module button_cmd_decoder #(
  parameter int unsigned LONG_CYCLES = 250000000,
  parameter int unsigned CNT_W       = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       feeding,
  input  logic       healing,
  input  logic       change,
  input  logic       testBut,
  input  logic       cmd_ack,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       test_mode,
  output logic       drop
);

  typedef enum logic [1:0] {StIdle, StHold, StLong} hold_state_e;

  localparam logic [2:0] CmdNone   = 3'd0;
  localparam logic [2:0] CmdFeed   = 3'd1;
  localparam logic [2:0] CmdHeal   = 3'd2;
  localparam logic [2:0] CmdChange = 3'd3;
  localparam logic [2:0] CmdToggle = 3'd4;
  localparam logic [2:0] CmdStep   = 3'd5;
  localparam logic [CNT_W-1:0] LongVal = CNT_W'(LONG_CYCLES);

  // Bit order: {testBut, change, healing, feeding}
  logic [3:0] r_q, r_qq;
  logic [3:0] w_rise;
  logic       w_fall_t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q  <= '0;
      r_qq <= '0;
    end else begin
      r_q  <= {testBut, change, healing, feeding};
      r_qq <= r_q;
    end
  end

  assign w_rise   = r_q & ~r_qq;
  assign w_fall_t = ~r_q[3] & r_qq[3];

  hold_state_e      r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_test_mode, w_test_mode_next;
  logic             w_tst_evt;
  logic [2:0]       w_tst_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_test_mode <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_test_mode <= w_test_mode_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_test_mode_next = r_test_mode;
    w_tst_evt        = 1'b0;
    w_tst_code       = CmdNone;
    unique case (r_state)
      StIdle: begin
        if (w_rise[3]) begin
          w_state_next = StHold;
          w_cnt_next   = CNT_W'(1);
        end
      end
      StHold: begin
        // Mode flips here even if the toggle token itself ends up dropped.
        if (r_cnt == LongVal) begin
          w_tst_evt        = 1'b1;
          w_tst_code       = CmdToggle;
          w_test_mode_next = ~r_test_mode;
          w_state_next     = StLong;
        end else if (w_fall_t) begin
          w_tst_evt    = r_test_mode;
          w_tst_code   = r_test_mode ? CmdStep : CmdNone;
          w_state_next = StIdle;
        end else if (r_q[3]) begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      StLong: begin
        if (w_fall_t) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  logic       w_offer;
  logic [2:0] w_offer_code;
  logic       w_arb_drop;
  logic       w_drop_next;
  logic       r_drop;

  always_comb begin
    w_offer      = 1'b1;
    w_offer_code = CmdNone;
    if (w_tst_evt)      w_offer_code = w_tst_code;
    else if (w_rise[0]) w_offer_code = CmdFeed;
    else if (w_rise[1]) w_offer_code = CmdHeal;
    else if (w_rise[2]) w_offer_code = CmdChange;
    else                w_offer      = 1'b0;
  end

  assign w_arb_drop = (w_tst_evt & (|w_rise[2:0])) | (w_rise[0] & (w_rise[1] | w_rise[2])) |
                      (w_rise[1] & w_rise[2]);

`ifdef BTN_CMD_FIFO_EN
  logic [2:0] r_mem [4];
  logic [1:0] r_wr, r_rd;
  logic [2:0] r_fcnt;
  logic       w_pop, w_push, w_full;

  assign w_full      = (r_fcnt == 3'd4);
  assign w_pop       = cmd_ack & (r_fcnt != 3'd0);
  assign w_push      = w_offer & (~w_full | w_pop);
  assign w_drop_next = w_arb_drop | (w_offer & ~w_push);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= CmdNone;
      r_wr   <= '0;
      r_rd   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_offer_code;
        r_wr        <= r_wr + 2'd1;
      end
      if (w_pop) r_rd <= r_rd + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 3'd1;
        2'b01:   r_fcnt <= r_fcnt - 3'd1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  assign cmd_valid = (r_fcnt != 3'd0);
  assign cmd_code  = cmd_valid ? r_mem[r_rd] : CmdNone;
`else
  logic       r_valid;
  logic [2:0] r_code;
  logic       w_accept;

  // Acked slot may be refilled in the same cycle, keeping valid high.
  assign w_accept    = w_offer & (~r_valid | cmd_ack);
  assign w_drop_next = w_arb_drop | (w_offer & ~w_accept);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_code  <= CmdNone;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_code  <= w_offer_code;
    end else if (r_valid && cmd_ack) begin
      r_valid <= 1'b0;
      r_code  <= CmdNone;
    end
  end

  assign cmd_valid = r_valid;
  assign cmd_code  = r_code;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_drop <= 1'b0;
    else     r_drop <= w_drop_next;
  end

  assign drop      = r_drop;
  assign test_mode = r_test_mode;

endmodule

// File: tb/tb_button_cmd_decoder.sv
// Directed bench for button_cmd_decoder (default single-register build, LONG_CYCLES=16).
module tb_button_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       feeding, healing, change, testBut, cmd_ack;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       test_mode, drop;

  int n_checks = 0;
  int n_fail   = 0;
  logic seen_v, seen_d;

  button_cmd_decoder #(
    .LONG_CYCLES(16),
    .CNT_W      (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .feeding  (feeding),
    .healing  (healing),
    .change   (change),
    .testBut  (testBut),
    .cmd_ack  (cmd_ack),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .test_mode(test_mode),
    .drop     (drop)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_once();
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; feeding = 0; healing = 0; change = 0; testBut = 0; cmd_ack = 0;
    tick(2);
    check_val("rst_valid", cmd_valid, 0);
    check_val("rst_code", cmd_code, 0);
    check_val("rst_tmode", test_mode, 0);
    check_val("rst_drop", drop, 0);
    rst = 1'b0;
    tick(2);

    // Feed: 3-cycle pulse, 2-cycle latency, held until ack
    feeding = 1; tick();
    check_val("feed_lat1", cmd_valid, 0);
    tick();
    check_val("feed_valid", cmd_valid, 1);
    check_val("feed_code", cmd_code, 1);
    check_val("feed_drop", drop, 0);
    tick(); feeding = 0;
    tick(4);
    check_val("feed_hold_v", cmd_valid, 1);
    check_val("feed_hold_c", cmd_code, 1);
    ack_once();
    check_val("feed_ack_v", cmd_valid, 0);
    check_val("feed_ack_c", cmd_code, 0);

    ack_once();
    check_val("idle_ack", cmd_valid, 0);

    // Short press with test_mode=0: nothing
    seen_v = 0; seen_d = 0;
    testBut = 1;
    for (int i = 0; i < 5; i++) begin tick(); seen_v |= cmd_valid; seen_d |= drop; end
    testBut = 0;
    for (int i = 0; i < 6; i++) begin tick(); seen_v |= cmd_valid; seen_d |= drop; end
    check_val("short_nomode_v", seen_v, 0);
    check_val("short_nomode_d", seen_d, 0);

    // Long press: toggle 17 cycles after q rises
    seen_v = 0;
    testBut = 1;
    for (int i = 0; i < 17; i++) begin tick(); seen_v |= cmd_valid; end
    check_val("long_early_v", seen_v, 0);
    check_val("long_early_tm", test_mode, 0);
    tick();
    check_val("long_valid", cmd_valid, 1);
    check_val("long_code", cmd_code, 4);
    check_val("long_tmode", test_mode, 1);
    tick(2); testBut = 0;
    ack_once();
    check_val("long_ack_v", cmd_valid, 0);
    seen_v = 0; seen_d = 0;
    for (int i = 0; i < 5; i++) begin tick(); seen_v |= cmd_valid; seen_d |= drop; end
    check_val("long_rel_v", seen_v, 0);
    check_val("long_rel_d", seen_d, 0);
    check_val("long_rel_tm", test_mode, 1);

    // Short press in test mode: TEST_STEP on release
    testBut = 1; tick(5); testBut = 0;
    tick();
    check_val("step_lat1", cmd_valid, 0);
    tick();
    check_val("step_valid", cmd_valid, 1);
    check_val("step_code", cmd_code, 5);
    ack_once();
    check_val("step_ack_v", cmd_valid, 0);

    // Simultaneous feed+heal: feed wins, one drop pulse
    feeding = 1; healing = 1;
    tick(2);
    check_val("simul_valid", cmd_valid, 1);
    check_val("simul_code", cmd_code, 1);
    check_val("simul_drop", drop, 1);
    tick();
    check_val("simul_drop_end", drop, 0);
    feeding = 0; healing = 0;
    ack_once();
    check_val("simul_ack_v", cmd_valid, 0);

    // Back-to-back replace: ack in the cycle the heal event is offered
    feeding = 1; tick(2);
    check_val("repl_first", cmd_code, 1);
    feeding = 0; healing = 1;
    tick();
    cmd_ack = 1; tick(); cmd_ack = 0;
    check_val("repl_valid", cmd_valid, 1);
    check_val("repl_code", cmd_code, 2);
    check_val("repl_drop", drop, 0);
    healing = 0;

    // Busy holding stage: change is dropped
    change = 1; tick(2);
    check_val("busy_drop", drop, 1);
    check_val("busy_code", cmd_code, 2);
    check_val("busy_valid", cmd_valid, 1);
    tick();
    check_val("busy_drop_end", drop, 0);
    change = 0;
    ack_once();
    check_val("busy_ack_v", cmd_valid, 0);

    // Reset mid-hold (count 10) with a pending command and test_mode=1
    feeding = 1; tick(2); feeding = 0;
    check_val("pre_rst_v", cmd_valid, 1);
    check_val("pre_rst_tm", test_mode, 1);
    testBut = 1; tick(11);
    rst = 1; #1;
    check_val("mid_rst_v", cmd_valid, 0);
    check_val("mid_rst_c", cmd_code, 0);
    check_val("mid_rst_tm", test_mode, 0);
    check_val("mid_rst_d", drop, 0);
    tick(); rst = 0;
    seen_v = 0;
    for (int i = 0; i < 17; i++) begin tick(); seen_v |= cmd_valid; end
    check_val("restart_early", seen_v, 0);
    tick();
    check_val("restart_valid", cmd_valid, 1);
    check_val("restart_code", cmd_code, 4);
    check_val("restart_tm", test_mode, 1);
    testBut = 0; tick(3);
    ack_once();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
